fc_argmax_stage: RTL and testbench
==================================

// Module: fc_argmax_stage
// PURPOSE
//  Output stage directly downstream of the FC_64 fully-connected layer. Accepts one frame of
//  NUM_CLASSES signed accumulator results on a valid/ready stream, requantizes each to OUT_W
//  bits, stores them in a score buffer, and emits the winning class index and its score.
//  The score buffer is readable for host readback through the AXI4-Lite register bank.
// PARAMETERS
//  NUM_CLASSES  64                    values per frame (FC output count)
//  IN_W         32                    signed accumulator width from the FC layer
//  OUT_W        8                     signed requantized score width
//  SHIFT        8                     arithmetic right shift applied before saturation
//  IDX_W        $clog2(NUM_CLASSES)   class index / buffer address width
// PORTS
//  clock     in   1       single clock domain
//  reset     in   1       synchronous, active-high
//  s_valid   in   1       input beat valid
//  s_ready   out  1       input beat accepted when s_valid && s_ready
//  s_data    in   IN_W    signed FC accumulator value, class order 0..NUM_CLASSES-1
//  s_last    in   1       marks final beat of frame
//  m_valid   out  1       result valid; held until m_ready
//  m_ready   in   1       result consumed
//  m_class   out  IDX_W   argmax index
//  m_score   out  OUT_W   score at argmax index
//  m_err     out  1       frame length mismatch flag for this result
//  rd_addr   in   IDX_W   score buffer read address
//  rd_data   out  OUT_W   score buffer data, 1-cycle read latency
// BEHAVIOUR
//  - Reset: state=COLLECT, beat count=0, m_valid/m_class/m_score/m_err=0, rd_data=0;
//    s_ready=0 while reset is high; score buffer contents not cleared.
//  - FSM COLLECT: s_ready=1. Each accepted beat: q = sat_OUT_W(s_data >>> SHIFT) (floor
//    shift, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]); write q to buffer[count]; count++.
//  - Argmax: beat 0 initializes best; later beat replaces best only if q > best (strict),
//    so ties resolve to the lowest index.
//  - Frame ends on the accepted beat where s_last=1 OR count==NUM_CLASSES-1, whichever first.
//    m_err=1 unless both coincide. Beats after a forced end start the next frame.
//  - End of frame -> EMIT next cycle: m_valid=1, m_class/m_score/m_err stable, s_ready=0.
//  - EMIT: on m_valid && m_ready -> COLLECT next cycle, m_valid=0, count=0.
//  - Latency: m_valid rises 1 cycle after the final beat handshake.
//  - Readback: rd_data registered from buffer[rd_addr]; legal any time; read and write to
//    the same address in one cycle returns the old value.
//  - Reset mid-frame discards partial frame; next frame starts at index 0.
// CONFIGURATION
//  FC_ARGMAX_RELU_EN defined: after saturation q = (q<0) ? 0 : q; stored and compared
//    values are non-negative (all-negative frame -> class 0, score 0).
//  Not defined: signed q stored and compared unchanged.
// STRUCTURE
//  fc_pkg: state enum {COLLECT, EMIT}, sat_q() function, default width constants.
//  Sub-module fc_score_ram: NUM_CLASSES x OUT_W simple dual-port RAM, 1 write port,
//  1 registered read port.
// TESTING
//  1. Frame s_data=i<<8, i=0..63, s_last on beat 63 -> m_class=63, m_score=63, m_err=0.
//  2. Beat 3=0x7FFFFFFF, beat 4=0x80000000, rest 0 -> buffer[3]=127; buffer[4]=-128
//     (0 with FC_ARGMAX_RELU_EN); m_class=3.
//  3. Beats 5 and 40 = 1000<<8, rest 0 -> saturated 127 tie -> m_class=5, m_score=127.
//  4. s_last on beat 9 -> m_err=1, result over beats 0..9; next 64-beat frame m_err=0.
//  5. m_ready low 20 cycles -> m_valid and outputs stable, s_ready=0; release -> s_ready=1
//     the following cycle.
//  6. Reset after 30 beats -> m_valid=0; fresh frame from test 1 gives class 63, m_err=0;
//     then rd_addr=10 -> rd_data=10 one cycle later.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and the requantize/saturate helper for fc_argmax_stage.
package fc_pkg;

  localparam int FC_NUM_CLASSES = 64;
  localparam int FC_IN_W        = 32;
  localparam int FC_OUT_W       = 8;
  localparam int FC_SHIFT       = 8;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } fc_state_e;

  localparam logic signed [FC_OUT_W-1:0] Q_MAX = {1'b0, {(FC_OUT_W-1){1'b1}}};
  localparam logic signed [FC_OUT_W-1:0] Q_MIN = {1'b1, {(FC_OUT_W-1){1'b0}}};
  localparam logic signed [FC_IN_W-1:0]  Q_MAX_WIDE = {{(FC_IN_W-FC_OUT_W+1){1'b0}}, {(FC_OUT_W-1){1'b1}}};
  localparam logic signed [FC_IN_W-1:0]  Q_MIN_WIDE = {{(FC_IN_W-FC_OUT_W+1){1'b1}}, {(FC_OUT_W-1){1'b0}}};

  // Floor shift (arithmetic) followed by saturation to the signed OUT_W range.
  function automatic logic signed [FC_OUT_W-1:0] sat_q(input logic signed [FC_IN_W-1:0] acc);
    logic signed [FC_IN_W-1:0]  sh;
    logic signed [FC_OUT_W-1:0] q;
    sh = acc >>> FC_SHIFT;
    if (sh > Q_MAX_WIDE) begin
      q = Q_MAX;
    end else if (sh < Q_MIN_WIDE) begin
      q = Q_MIN;
    end else begin
      q = sh[FC_OUT_W-1:0];
    end
    return q;
  endfunction

endpackage

// File: rtl/fc_score_ram.sv
// Score buffer: simple dual-port RAM, one write port and one registered read port (old data on collision).
module fc_score_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= {DATA_W{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/fc_argmax_stage.sv
// FC output stage: requantize a frame of accumulators, buffer the scores, emit argmax index and score.
// Optional macro FC_ARGMAX_RELU_EN clamps negative requantized scores to zero.
import fc_pkg::*;

module fc_argmax_stage #(
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int IN_W        = FC_IN_W,
  parameter int OUT_W       = FC_OUT_W,
  parameter int SHIFT       = FC_SHIFT,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IDX_W-1:0] m_class,
  output logic [OUT_W-1:0] m_score,
  output logic             m_err,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  localparam logic [0:0] ST_COLLECT = COLLECT;
  localparam logic [0:0] ST_EMIT    = EMIT;

  logic [0:0]              state_r;
  logic [IDX_W-1:0]        count_r;
  logic [IDX_W-1:0]        best_class_r;
  logic signed [OUT_W-1:0] best_score_r;
  logic signed [OUT_W-1:0] q_sat_s;
  logic signed [OUT_W-1:0] q_s;
  logic signed [OUT_W-1:0] nb_score_s;
  logic [IDX_W-1:0]        nb_class_s;
  logic                    accept_s;
  logic                    last_slot_s;
  logic                    frame_end_s;

  assign s_ready     = (state_r == ST_COLLECT) && !reset;
  assign accept_s    = s_valid && s_ready;
  assign last_slot_s = (count_r == IDX_W'(NUM_CLASSES-1));
  assign frame_end_s = accept_s && (s_last || last_slot_s);
  assign q_sat_s     = sat_q(s_data);

  // Optional rectification of the saturated score.
  always_comb begin
`ifdef FC_ARGMAX_RELU_EN
    q_s = q_sat_s[OUT_W-1] ? {OUT_W{1'b0}} : q_sat_s;
`else
    q_s = q_sat_s;
`endif
  end

  // Running argmax including the current beat; strict compare keeps the lowest index on ties.
  always_comb begin
    nb_score_s = best_score_r;
    nb_class_s = best_class_r;
    if ((count_r == {IDX_W{1'b0}}) || (q_s > best_score_r)) begin
      nb_score_s = q_s;
      nb_class_s = count_r;
    end else begin
      nb_score_s = best_score_r;
      nb_class_s = best_class_r;
    end
  end

  // Frame collection / result hold FSM with registered result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_COLLECT;
      count_r      <= {IDX_W{1'b0}};
      best_class_r <= {IDX_W{1'b0}};
      best_score_r <= {OUT_W{1'b0}};
      m_valid      <= 1'b0;
      m_class      <= {IDX_W{1'b0}};
      m_score      <= {OUT_W{1'b0}};
      m_err        <= 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (accept_s) begin
            best_score_r <= nb_score_s;
            best_class_r <= nb_class_s;
            if (frame_end_s) begin
              state_r <= ST_EMIT;
              count_r <= {IDX_W{1'b0}};
              m_valid <= 1'b1;
              m_class <= nb_class_s;
              m_score <= nb_score_s;
              m_err   <= !(s_last && last_slot_s);
            end else begin
              count_r <= count_r + IDX_W'(1'b1);
            end
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            state_r <= ST_COLLECT;
            m_valid <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
          count_r <= {IDX_W{1'b0}};
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  fc_score_ram #(
    .DEPTH  (NUM_CLASSES),
    .ADDR_W (IDX_W),
    .DATA_W (OUT_W)
  ) u_score_ram (
    .clock (clock),
    .reset (reset),
    .we    (accept_s),
    .waddr (count_r),
    .wdata (q_s),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_fc_argmax_stage.sv
// Self-checking bench for fc_argmax_stage: directed vector table, corner sequences, random frames vs model.
module tb_fc_argmax_stage;

  localparam int N = 64;
`ifdef FC_ARGMAX_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'd0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [5:0]  m_class;
  logic [7:0]  m_score;
  logic        m_err;
  logic [5:0]  rd_addr = 6'd0;
  logic [7:0]  rd_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] fdata [N];
  int shadow [N];

  typedef struct {
    int    kind;
    int    n;
    bit    last;
    int    exp_class;
    int    exp_score;
    int    exp_err;
    string name;
  } vec_t;
  vec_t vecs [8];

  fc_argmax_stage dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .m_score(m_score), .m_err(m_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected done");
    $fatal(1);
  end

  function automatic int model_q(logic [31:0] d);
    longint v, f;
    v = longint'($signed(d));
    f = v / 256;
    if ((v % 256) != 0 && v < 0) f = f - 1;
    if (f > 127) f = 127;
    if (f < -128) f = -128;
    if (RELU && f < 0) f = 0;
    return int'(f);
  endfunction

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill(int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: fdata[i] = 32'(i) << 8;
        1: fdata[i] = (i == 3) ? 32'h7FFF_FFFF : ((i == 4) ? 32'h8000_0000 : 32'd0);
        2: fdata[i] = (i == 5 || i == 40) ? (32'd1000 << 8) : 32'd0;
        default: fdata[i] = -(32'd1000 << 8);
      endcase
    end
  endtask

  task automatic send_beat(logic [31:0] d, logic last);
    int guard = 0;
    @(negedge clock);
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge clock); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(int n, bit last);
    for (int i = 0; i < n; i++) begin
      send_beat(fdata[i], last && (i == n - 1));
      shadow[i] = model_q(fdata[i]);
    end
  endtask

  task automatic expect_result(string name, int c, int s, int e);
    @(negedge clock);
    check({name, "_valid"}, int'(m_valid), 1);
    check({name, "_class"}, int'(m_class), c);
    check({name, "_score"}, int'($signed(m_score)), s);
    check({name, "_err"}, int'(m_err), e);
  endtask

  task automatic consume(string name);
    m_ready = 1'b1;
    @(posedge clock); #1;
    m_ready = 1'b0;
    @(negedge clock);
    check({name, "_valid_drop"}, int'(m_valid), 0);
    check({name, "_ready_back"}, int'(s_ready), 1);
  endtask

  task automatic read_check(string name, int addr, int exp);
    @(negedge clock);
    rd_addr = 6'(addr);
    @(posedge clock);
    @(negedge clock);
    check(name, int'($signed(rd_data)), exp);
  endtask

  task automatic model_argmax(int n, output int c, output int s);
    c = 0; s = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || model_q(fdata[i]) > s) begin
        c = i; s = model_q(fdata[i]);
      end
    end
  endtask

  initial begin
    int ec, es, n, old0, new0, r;
    bit lst;

    vecs[0] = '{0, 64, 1'b1, 63, 63, 0, "ramp"};
    vecs[1] = '{1, 64, 1'b1, 3, 127, 0, "extreme"};
    vecs[2] = '{2, 64, 1'b1, 5, 127, 0, "tie"};
    vecs[3] = '{0, 10, 1'b1, 9, 9, 1, "short_last"};
    vecs[4] = '{0, 64, 1'b1, 63, 63, 0, "after_short"};
    vecs[5] = '{3, 64, 1'b1, 0, (RELU ? 0 : -128), 0, "all_neg"};
    vecs[6] = '{0, 64, 1'b0, 63, 63, 1, "forced_end"};
    vecs[7] = '{0, 64, 1'b1, 63, 63, 0, "after_forced"};

    // Reset state
    @(negedge clock);
    check("reset_s_ready", int'(s_ready), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_class", int'(m_class), 0);
    check("reset_m_score", int'(m_score), 0);
    check("reset_m_err", int'(m_err), 0);
    check("reset_rd_data", int'(rd_data), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].kind);
      send_frame(vecs[v].n, vecs[v].last);
      expect_result(vecs[v].name, vecs[v].exp_class, vecs[v].exp_score, vecs[v].exp_err);
      consume(vecs[v].name);
      if (vecs[v].kind == 1) begin
        read_check("buf3_max", 3, 127);
        read_check("buf4_min", 4, RELU ? 0 : -128);
      end
    end

    // Result held under backpressure
    fill(0);
    send_frame(64, 1'b1);
    expect_result("stall", 63, 63, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("stall_valid", int'(m_valid), 1);
      check("stall_class", int'(m_class), 63);
      check("stall_score", int'($signed(m_score)), 63);
      check("stall_s_ready", int'(s_ready), 0);
    end
    consume("stall");

    // Read and write of the same address in one cycle returns the old value
    old0 = shadow[0];
    for (int i = 0; i < N; i++) fdata[i] = 32'(i + 1) << 8;
    fdata[0] = ((old0 == 5) ? 32'd6 : 32'd5) << 8;
    new0 = model_q(fdata[0]);
    @(negedge clock);
    rd_addr = 6'd0;
    send_beat(fdata[0], 1'b0);
    @(negedge clock);
    check("rw_same_old", int'($signed(rd_data)), old0);
    send_beat(fdata[1], 1'b0);
    @(negedge clock);
    check("rw_same_new", int'($signed(rd_data)), new0);
    shadow[0] = new0;
    shadow[1] = model_q(fdata[1]);
    for (int i = 2; i < N; i++) begin
      send_beat(fdata[i], i == N - 1);
      shadow[i] = model_q(fdata[i]);
    end
    model_argmax(N, ec, es);
    expect_result("rw_frame", ec, es, 0);
    consume("rw_frame");

    // Reset in the middle of a frame
    fill(0);
    send_frame(30, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_s_ready", int'(s_ready), 0);
    @(posedge clock);
    @(negedge clock);
    check("midreset_m_valid", int'(m_valid), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    send_frame(64, 1'b1);
    expect_result("post_reset", 63, 63, 0);
    consume("post_reset");
    read_check("readback10", 10, 10);

    // Random frames against the reference model
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 64);
      lst = (n < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0) fdata[i] = $urandom;
        else fdata[i] = 32'($urandom_range(0, 80000)) - 32'd40000;
      end
      send_frame(n, lst);
      model_argmax(n, ec, es);
      expect_result("rand", ec, es, (lst && n == 64) ? 0 : 1);
      consume("rand");
      r = $urandom_range(0, n - 1);
      read_check("rand_readback", r, shadow[r]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
